// File: rtl/mipse_lsu_if.sv
// Core/memory-side signal bundle for the mipse load/store unit.
// The slave view is the LSU itself; the master view is the core plus data memory.
interface mipse_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int LANES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [LANES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [1:0]        err_code;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output resp_valid, resp_rdata, resp_err, err_code
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  resp_valid, resp_rdata, resp_err, err_code
  );
endinterface

// File: rtl/mipse_lsu.sv
// Load/store unit: big-endian byte/half/word(/dword) accesses over a valid/ready
// memory handshake with timeout, returning sign/zero-extended load data.
module mipse_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  mipse_lsu_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg;
  logic [15:0]       cnt_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [3:0]        nbytes_reg;
  logic              uns_reg;
  logic              we_reg;

  logic              req_ready_reg;
  logic              mem_valid_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_we_reg;
  logic [LANES-1:0]  mem_be_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              resp_valid_reg;
  logic [DATA_W-1:0] resp_rdata_reg;
  logic              resp_err_reg;
  logic [1:0]        err_code_reg;

  // Request decode, evaluated on the incoming request while idle
  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_nbytes;
  logic              req_misalign;
  logic [LANES-1:0]  req_be;
  logic [DATA_W-1:0] req_lane_wdata;

  always_comb begin
    req_off        = bus.req_addr[OFF_W-1:0];
    req_nbytes     = 4'd1 << bus.req_size;
    req_misalign   = ((4'(req_off) & (req_nbytes - 4'd1)) != 4'd0) ||
                     ((bus.req_size == 2'd3) && (LANES == 4));
    // Right-aligned store data: push the field to the MSB lane, then down to lane o
    req_lane_wdata = bus.req_wdata << (DATA_W - 8 * int'(req_nbytes));
    req_lane_wdata = req_lane_wdata >> (8 * int'(req_off));
    if (!bus.req_we) begin
      req_lane_wdata = '0;
    end
  end

  // Lane gi is byte offset gi, which sits at mem_be bit LANES-1-gi
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_be
      assign req_be[LANES-1-gi] = (gi >= int'(req_off)) &&
                                  (gi < int'(req_off) + int'(req_nbytes));
    end
  endgenerate

  // Load extraction: selected field moved to the MSB, then shifted down with extension
  logic [DATA_W-1:0] rd_left;
  logic [DATA_W-1:0] rd_ext;

  always_comb begin
    rd_left = bus.mem_rdata << (8 * int'(off_reg));
    if (uns_reg) begin
      rd_ext = rd_left >> (DATA_W - 8 * int'(nbytes_reg));
    end else begin
      rd_ext = $signed(rd_left) >>> (DATA_W - 8 * int'(nbytes_reg));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      off_reg        <= '0;
      nbytes_reg     <= '0;
      uns_reg        <= 1'b0;
      we_reg         <= 1'b0;
      req_ready_reg  <= 1'b1;
      mem_valid_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      err_code_reg   <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (bus.req_valid) begin
            off_reg       <= req_off;
            nbytes_reg    <= req_nbytes;
            uns_reg       <= bus.req_unsigned;
            we_reg        <= bus.req_we;
            req_ready_reg <= 1'b0;
            if (req_misalign) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_rdata_reg <= '0;
              resp_err_reg   <= 1'b1;
              err_code_reg   <= 2'b01;
            end else begin
              state_reg     <= ACCESS;
              mem_valid_reg <= 1'b1;
              mem_addr_reg  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_we_reg    <= bus.req_we;
              mem_be_reg    <= req_be;
              mem_wdata_reg <= req_lane_wdata;
            end
          end
        end
        ACCESS: begin
          // A ready on the final counted cycle still wins over the timeout
          if (bus.mem_ready || (cnt_reg + 16'd1 == TIMEOUT_CNT)) begin
            state_reg      <= RESP;
            cnt_reg        <= '0;
            mem_valid_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= '0;
            mem_wdata_reg  <= '0;
            resp_valid_reg <= 1'b1;
            if (bus.mem_ready) begin
              resp_rdata_reg <= we_reg ? '0 : rd_ext;
              resp_err_reg   <= 1'b0;
              err_code_reg   <= 2'b00;
            end else begin
              resp_rdata_reg <= '0;
              resp_err_reg   <= 1'b1;
              err_code_reg   <= 2'b10;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        RESP: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
          err_code_reg   <= 2'b00;
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.mem_valid  = mem_valid_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_be     = mem_be_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.err_code   = err_code_reg;
endmodule

// File: tb/tb_mipse_lsu.sv
// Directed bench for mipse_lsu: 32-bit unit (TIMEOUT=4) and 64-bit unit (TIMEOUT=8),
// responses checked by per-unit scoreboards fed at issue time.
module tb_mipse_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mipse_lsu_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mipse_lsu_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  mipse_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave));
  mipse_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) dut64 (
    .clk(clk), .rst(rst), .bus(b64.slave));

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic [1:0]  code;
  } resp_t;

  resp_t q32[$];
  resp_t q64[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    resp_t e;
    if (b32.resp_valid) begin
      if (q32.size() == 0) begin
        chk("resp32_unexpected", 64'(b32.resp_valid), 64'd0);
      end else begin
        e = q32.pop_front();
        chk("resp32_rdata", 64'(b32.resp_rdata), e.rdata);
        chk("resp32_err", 64'(b32.resp_err), 64'(e.err));
        chk("resp32_code", 64'(b32.err_code), 64'(e.code));
        $display("resp32 rdata=0x%08h err=%0d code=%0d", b32.resp_rdata, b32.resp_err, b32.err_code);
      end
    end
  end

  always @(negedge clk) begin
    resp_t e;
    if (b64.resp_valid) begin
      if (q64.size() == 0) begin
        chk("resp64_unexpected", 64'(b64.resp_valid), 64'd0);
      end else begin
        e = q64.pop_front();
        chk("resp64_rdata", b64.resp_rdata, e.rdata);
        chk("resp64_err", 64'(b64.resp_err), 64'(e.err));
        chk("resp64_code", 64'(b64.err_code), 64'(e.code));
        $display("resp64 rdata=0x%016h err=%0d code=%0d", b64.resp_rdata, b64.resp_err, b64.err_code);
      end
    end
  end

  task automatic run32(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int lows, input int exp_cyc, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                       input logic exp_err, input logic [1:0] exp_code);
    resp_t e;
    int cyc;
    @(negedge clk);
    chk({name, "_req_ready"}, 64'(b32.req_ready), 64'd1);
    e.rdata = 64'(exp_rd);
    e.err   = exp_err;
    e.code  = exp_code;
    q32.push_back(e);
    b32.req_valid    = 1'b1;
    b32.req_we       = we;
    b32.req_size     = size;
    b32.req_unsigned = uns;
    b32.req_addr     = addr;
    b32.req_wdata    = wdata;
    b32.mem_rdata    = rdata;
    @(negedge clk);
    b32.req_valid = 1'b0;
    cyc = 0;
    while (b32.mem_valid && cyc < 40) begin
      chk({name, "_mem_addr"}, 64'(b32.mem_addr), 64'({addr[31:2], 2'b00}));
      chk({name, "_mem_be"}, 64'(b32.mem_be), 64'(exp_be));
      chk({name, "_mem_wdata"}, 64'(b32.mem_wdata), 64'(exp_wd));
      chk({name, "_mem_we"}, 64'(b32.mem_we), 64'(we));
      if (cyc == lows) b32.mem_ready = 1'b1;
      @(negedge clk);
      b32.mem_ready = 1'b0;
      cyc++;
    end
    chk({name, "_mem_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({name, "_resp_timing"}, 64'(b32.resp_valid), 64'd1);
    @(negedge clk);
    chk({name, "_back_idle"}, 64'(b32.req_ready), 64'd1);
  endtask

  task automatic run64(input string name, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] rdata, input int lows,
                       input int exp_cyc, input logic [7:0] exp_be, input logic [63:0] exp_rd);
    resp_t e;
    int cyc;
    @(negedge clk);
    chk({name, "_req_ready"}, 64'(b64.req_ready), 64'd1);
    e.rdata = exp_rd;
    e.err   = 1'b0;
    e.code  = 2'b00;
    q64.push_back(e);
    b64.req_valid    = 1'b1;
    b64.req_we       = 1'b0;
    b64.req_size     = size;
    b64.req_unsigned = uns;
    b64.req_addr     = addr;
    b64.mem_rdata    = rdata;
    @(negedge clk);
    b64.req_valid = 1'b0;
    cyc = 0;
    while (b64.mem_valid && cyc < 40) begin
      chk({name, "_mem_addr"}, 64'(b64.mem_addr), 64'({addr[31:3], 3'b000}));
      chk({name, "_mem_be"}, 64'(b64.mem_be), 64'(exp_be));
      if (cyc == lows) b64.mem_ready = 1'b1;
      @(negedge clk);
      b64.mem_ready = 1'b0;
      cyc++;
    end
    chk({name, "_mem_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({name, "_resp_timing"}, 64'(b64.resp_valid), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_size = 2'd0; b32.req_unsigned = 1'b0;
    b32.req_addr = '0; b32.req_wdata = '0; b32.mem_ready = 1'b0; b32.mem_rdata = '0;
    b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_size = 2'd0; b64.req_unsigned = 1'b0;
    b64.req_addr = '0; b64.req_wdata = '0; b64.mem_ready = 1'b0; b64.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(b32.req_ready), 64'd1);
    chk("rst_mem_valid", 64'(b32.mem_valid), 64'd0);
    chk("rst_resp_valid", 64'(b32.resp_valid), 64'd0);
    chk("rst_err_code", 64'(b32.err_code), 64'd0);
    chk("rst64_req_ready", 64'(b64.req_ready), 64'd1);
    rst = 1'b0;

    // Stray mem_ready while idle must not start or finish anything
    b32.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready_mem_valid", 64'(b32.mem_valid), 64'd0);
    chk("idle_ready_resp_valid", 64'(b32.resp_valid), 64'd0);
    b32.mem_ready = 1'b0;

    //    name        we  sz  uns addr        wdata         rdata         lows cyc be       wdata_exp     resp          err  code
    run32("lb_s",     0, 2'd0, 0, 32'h101, 32'h0,        32'h12F45678, 0,  1, 4'b0100, 32'h0,        32'hFFFFFFF4, 0, 2'b00);
    run32("lb_u",     0, 2'd0, 1, 32'h101, 32'h0,        32'h12F45678, 0,  1, 4'b0100, 32'h0,        32'h000000F4, 0, 2'b00);
    run32("lh_s",     0, 2'd1, 0, 32'h102, 32'h0,        32'h12348001, 0,  1, 4'b0011, 32'h0,        32'hFFFF8001, 0, 2'b00);
    run32("sh_stall", 1, 2'd1, 0, 32'h202, 32'hAAAABEEF, 32'h0,        3,  4, 4'b0011, 32'h0000BEEF, 32'h0,        0, 2'b00);
    run32("lw_mis",   0, 2'd2, 0, 32'h3,   32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1, 2'b01);
    run32("lw_tmo",   0, 2'd2, 0, 32'h10,  32'h0,        32'h55555555, 99, 4, 4'b1111, 32'h0,        32'h0,        1, 2'b10);
    run32("lw_last",  0, 2'd2, 0, 32'h14,  32'h0,        32'hDEADBEEF, 3,  4, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 2'b00);
    run32("sb_o3",    1, 2'd0, 0, 32'h7,   32'h123456A5, 32'h0,        0,  1, 4'b0001, 32'h000000A5, 32'h0,        0, 2'b00);
    run32("lb_u_o0",  0, 2'd0, 1, 32'h20,  32'h0,        32'h80FFFFFF, 1,  2, 4'b1000, 32'h0,        32'h00000080, 0, 2'b00);
    run32("lh_s_o0",  0, 2'd1, 0, 32'h24,  32'h0,        32'h7FFF0000, 0,  1, 4'b1100, 32'h0,        32'h00007FFF, 0, 2'b00);
    run32("lh_mis",   0, 2'd1, 0, 32'h1,   32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1, 2'b01);
    run32("ld_on32",  0, 2'd3, 0, 32'h0,   32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1, 2'b01);
    run32("sw",       1, 2'd2, 0, 32'h30,  32'h01020304, 32'h0,        0,  1, 4'b1111, 32'h01020304, 32'h0,        0, 2'b00);

    run64("ld64",     2'd3, 0, 32'h8,  64'h0123456789ABCDEF, 0, 1, 8'hFF, 64'h0123456789ABCDEF);
    run64("lb64_o7",  2'd0, 0, 32'hF,  64'h01234567890000EF, 0, 1, 8'h01, 64'hFFFFFFFFFFFFFFEF);
    run64("lw64_u",   2'd2, 1, 32'h14, 64'h0123456789ABCDEF, 2, 3, 8'h0F, 64'h0000000089ABCDEF);

    // Reset in the middle of an access: mem_valid drops at once, no response follows
    @(negedge clk);
    b64.req_valid = 1'b1; b64.req_we = 1'b0; b64.req_size = 2'd2; b64.req_addr = 32'h20;
    @(negedge clk);
    b64.req_valid = 1'b0;
    chk("rst_mid_pre_mem_valid", 64'(b64.mem_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_valid", 64'(b64.mem_valid), 64'd0);
    chk("rst_mid_req_ready", 64'(b64.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    b64.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", 64'(b64.resp_valid), 64'd0);
    end
    b64.mem_ready = 1'b0;
    chk("sb32_drained", 64'(q32.size()), 64'd0);
    chk("sb64_drained", 64'(q64.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mipse_lsu.md
Name: mipse_lsu

Overview:
- Parametrised load/store unit for the next-generation mipse core. Replaces the single-cycle, word-only, always-ready memory path.
- Accepts one load/store request from the core and performs byte/halfword/word (and doubleword when DATA_W=64) accesses. Lanes are big-endian.
- Talks to data memory over a valid/ready handshake with a timeout, returns sign- or zero-extended load data, and flags misaligned and timed-out accesses.
- Sits between the core's execute stage and data memory; the core stalls while req_ready is low.

Parameters:
- DATA_W, 32, memory/register data width; must be 32 or 64; LANES = DATA_W/8.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum ACCESS cycles without mem_ready before a bus error (1..65535).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit idle, request accepted when req_valid & req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 byte, 1 half, 2 word, 3 dword (only legal when DATA_W=64).
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data, right-aligned.
- mem_valid  output  1  memory request.
- mem_ready  input  1  memory completes the request this cycle.
- mem_addr  output  ADDR_W  req_addr with low log2(LANES) bits cleared.
- mem_we  output  1  write strobe.
- mem_be  output  LANES  byte enables; byte offset o maps to mem_be[LANES-1-o].
- mem_wdata  output  DATA_W  lane-positioned store data; non-enabled lanes are 0.
- mem_rdata  input  DATA_W  read data, valid when mem_valid & mem_ready.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- resp_err  output  1  access failed.
- err_code  output  2  01 misaligned, 10 timeout, 00 otherwise.

Behaviour:
- Reset: state IDLE, req_ready=1, every other output 0, timeout counter 0. Reset asserted mid-ACCESS drops mem_valid immediately and discards the access; no response is produced.
- Byte offset o = req_addr[log2(LANES)-1:0]. Byte offset o occupies data bits [DATA_W-1-8o -: 8], so offset 0 is the MSB byte.
- Alignment: an access is misaligned when o mod (1<<req_size) != 0, or when req_size=3 with DATA_W=32.
- IDLE:
  - req_ready=1. On acceptance, all request fields are latched.
  - If misaligned: go to RESP with err=01. No memory transaction is issued.
  - Otherwise: go to ACCESS.
- ACCESS:
  - mem_valid=1. mem_addr, mem_we, mem_be and mem_wdata come from registers and stay stable until the handshake completes.
  - mem_be has (1<<size) contiguous bits set starting at lane o.
  - The counter increments each cycle mem_ready is low.
  - On mem_ready: capture and extract the selected bytes, extend them to DATA_W, and go to RESP.
  - If the counter reaches TIMEOUT with mem_ready still low: mem_valid falls next cycle and the unit goes to RESP with err=10.
  - mem_ready arriving in the same cycle as the TIMEOUT count counts as success.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata/resp_err/err_code valid. Next state is IDLE. req_ready=0 in both ACCESS and RESP.
- Latency: acceptance at cycle N, mem_valid at N+1. With mem_ready at N+1, resp_valid is at N+2, and a new request can be accepted at N+3. Misaligned: resp_valid at N+1.
- mem_ready received outside ACCESS is ignored.
- req_valid received while busy is ignored; the core must hold the request until req_ready is high.
- Extension: with req_unsigned=0, the MSB of the extracted field is replicated. Stores always return resp_rdata=0.

Test Plan:
- Load byte, sign-extended: DATA_W=32, addr 0x101, mem_rdata 0x12_F4_56_78, mem_ready on first ACCESS cycle -> mem_addr 0x100, mem_be 4'b0100, resp_rdata 0xFFFFFFF4 two cycles after acceptance.
- Same load with req_unsigned=1 -> resp_rdata 0x000000F4. Halfword at addr 0x102 reading 0x1234_8001 -> signed result 0xFFFF8001.
- Store half: addr 0x202, wdata 0xAAAA_BEEF -> mem_be 4'b0011, mem_wdata 0x0000_BEEF, mem_we=1. Hold mem_ready low for 3 cycles -> outputs stable throughout, resp_valid 1 cycle after mem_ready, resp_err=0.
- Misaligned word at addr 0x3 -> mem_valid never rises, resp_valid next cycle, resp_err=1, err_code=01.
- TIMEOUT=4, mem_ready held low -> mem_valid high for exactly 4 cycles, then resp_err=1, err_code=10. Repeat the run with mem_ready arriving on the 4th cycle -> success.
- DATA_W=64 dword load at addr 0x8 -> mem_be 8'hFF, full rdata returned. Separately, assert rst during ACCESS -> mem_valid=0 immediately, req_ready=1, no resp_valid pulse.
